// File: rtl/attack_sequencer.sv
// Per-player attack/stun phase sequencer; one clk_game cycle is one game frame.
// Drives the attack_phase code seen by hit detection and gates player movement.
module attack_sequencer #(
    parameter int unsigned STARTUP_FRAMES   = 5,
    parameter int unsigned ACTIVE_FRAMES    = 2,
    parameter int unsigned RECOVERY_FRAMES  = 16,
    parameter int unsigned HITSTUN_FRAMES   = 15,
    parameter int unsigned BLOCKSTUN_FRAMES = 10,
    parameter int unsigned BUFFER_FRAMES    = 4,
    parameter int unsigned CNT_W            = 5
) (
    input  logic             clk_game,
    input  logic             reset_n,
    input  logic             game_active,
    input  logic             attack_btn,
    input  logic             got_hit,
    input  logic             got_blocked,
    output logic [1:0]       attack_phase,
    output logic             attack_start,
    output logic             stunned,
    output logic             move_enable,
    output logic [CNT_W-1:0] frames_left
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STARTUP   = 3'd1,
        S_ACTIVE    = 3'd2,
        S_RECOVERY  = 3'd3,
        S_HITSTUN   = 3'd4,
        S_BLOCKSTUN = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LD_STARTUP   = CNT_W'(STARTUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] LD_ACTIVE    = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] LD_RECOVERY  = CNT_W'(RECOVERY_FRAMES - 1);
    localparam logic [CNT_W-1:0] LD_HITSTUN   = CNT_W'(HITSTUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] LD_BLOCKSTUN = CNT_W'(BLOCKSTUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] BUF_LIM      = CNT_W'(BUFFER_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_prev;
    logic             r_buf;
    logic [1:0]       r_phase;
    logic             r_start;
    logic             r_stun;
    logic             r_move;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_next_buf;
    logic [1:0]       w_next_phase;
    logic             w_next_start;
    logic             w_next_stun;
    logic             w_next_move;
    logic             w_press;
    logic             w_cnt_zero;
    logic             w_buf_press;

    assign w_press     = attack_btn & ~r_btn_prev;
    assign w_cnt_zero  = (r_cnt == CNT_ZERO);
    assign w_buf_press = w_press & (r_cnt < BUF_LIM);

    // State, frame counter, buffer flag and button history registers
    always_ff @(posedge clk_game) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= CNT_ZERO;
            r_btn_prev <= 1'b0;
            r_buf      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_btn_prev <= attack_btn;
            r_buf      <= w_next_buf;
        end
    end

    // Next-state logic: round gating, then hit, then block, then normal sequencing
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_buf   = r_buf;
        if (!game_active) begin
            w_next_state = S_IDLE;
            w_next_cnt   = CNT_ZERO;
            w_next_buf   = 1'b0;
        end else if (got_hit) begin
            w_next_state = S_HITSTUN;
            w_next_cnt   = LD_HITSTUN;
            w_next_buf   = 1'b0;
        end else if (got_blocked && (r_state != S_HITSTUN)) begin
            w_next_state = S_BLOCKSTUN;
            w_next_cnt   = LD_BLOCKSTUN;
            w_next_buf   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_cnt = CNT_ZERO;
                    w_next_buf = 1'b0;
                    if (w_press) begin
                        w_next_state = S_STARTUP;
                        w_next_cnt   = LD_STARTUP;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_STARTUP: begin
                    if (w_cnt_zero) begin
                        w_next_state = S_ACTIVE;
                        w_next_cnt   = LD_ACTIVE;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_ACTIVE: begin
                    if (w_cnt_zero) begin
                        w_next_state = S_RECOVERY;
                        w_next_cnt   = LD_RECOVERY;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_RECOVERY: begin
                    // A press landing on the final frame still chains the next attack
                    if (w_cnt_zero) begin
                        w_next_buf = 1'b0;
                        if (r_buf || w_buf_press) begin
                            w_next_state = S_STARTUP;
                            w_next_cnt   = LD_STARTUP;
                        end else begin
                            w_next_state = S_IDLE;
                            w_next_cnt   = CNT_ZERO;
                        end
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                        if (w_buf_press) begin
                            w_next_buf = 1'b1;
                        end else begin
                            w_next_buf = r_buf;
                        end
                    end
                end
                S_HITSTUN, S_BLOCKSTUN: begin
                    if (w_cnt_zero) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = CNT_ZERO;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = CNT_ZERO;
                    w_next_buf   = 1'b0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every output is registered
    always_comb begin
        w_next_phase = 2'b00;
        w_next_stun  = 1'b0;
        case (w_next_state)
            S_IDLE:      w_next_phase = 2'b00;
            S_STARTUP:   w_next_phase = 2'b01;
            S_ACTIVE:    w_next_phase = 2'b10;
            S_RECOVERY:  w_next_phase = 2'b11;
            S_HITSTUN:   w_next_stun  = 1'b1;
            S_BLOCKSTUN: w_next_stun  = 1'b1;
            default: begin
                w_next_phase = 2'b00;
                w_next_stun  = 1'b0;
            end
        endcase
        w_next_start = (w_next_state == S_STARTUP) && (r_state != S_STARTUP);
        w_next_move  = (w_next_state == S_IDLE) && game_active;
    end

    // Registered outputs
    always_ff @(posedge clk_game) begin
        if (!reset_n) begin
            r_phase <= 2'b00;
            r_start <= 1'b0;
            r_stun  <= 1'b0;
            r_move  <= 1'b0;
        end else begin
            r_phase <= w_next_phase;
            r_start <= w_next_start;
            r_stun  <= w_next_stun;
            r_move  <= w_next_move;
        end
    end

    assign attack_phase = r_phase;
    assign attack_start = r_start;
    assign stunned      = r_stun;
    assign move_enable  = r_move;
    assign frames_left  = r_cnt;

endmodule

// File: tb/tb_attack_sequencer.sv
// Table-driven bench for attack_sequencer with default parameters: each record
// gives one frame of inputs and the outputs expected right after that frame's edge.
module tb_attack_sequencer;

    logic       clk_game = 1'b0;
    logic       reset_n;
    logic       game_active;
    logic       attack_btn;
    logic       got_hit;
    logic       got_blocked;
    logic [1:0] attack_phase;
    logic       attack_start;
    logic       stunned;
    logic       move_enable;
    logic [4:0] frames_left;

    attack_sequencer dut (
        .clk_game    (clk_game),
        .reset_n     (reset_n),
        .game_active (game_active),
        .attack_btn  (attack_btn),
        .got_hit     (got_hit),
        .got_blocked (got_blocked),
        .attack_phase(attack_phase),
        .attack_start(attack_start),
        .stunned     (stunned),
        .move_enable (move_enable),
        .frames_left (frames_left)
    );

    always #5 clk_game = ~clk_game;

    typedef struct {
        logic       rst_n;
        logic       ga;
        logic       btn;
        logic       hit;
        logic       blk;
        logic [1:0] ph;
        logic       st;
        logic       stn;
        logic       mv;
        logic [4:0] fl;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] ph;
        logic       st;
        logic       stn;
        logic       mv;
        logic [4:0] fl;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic g, input logic b, input logic h,
                       input logic k, input logic [1:0] ph, input logic st,
                       input logic sn, input logic mv, input logic [4:0] fl);
        vec_t v;
        v.rst_n = r; v.ga = g; v.btn = b; v.hit = h; v.blk = k;
        v.ph = ph; v.st = st; v.stn = sn; v.mv = mv; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic b);
        add(1'b1, 1'b1, b, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0);
    endtask

    // Startup frames after the entry frame, both active frames, recovery down to rec_stop
    task automatic attack_tail(input int rec_stop);
        for (int i = 3; i >= 0; i--) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 5'(i));
        for (int i = 1; i >= 0; i--) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 5'(i));
        for (int i = 15; i >= rec_stop; i--) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'(i));
    endtask

    task automatic attack_from_idle(input int rec_stop);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd4);
        attack_tail(rec_stop);
    endtask

    task automatic stun_run(input int from, input int to, input logic b);
        for (int i = from; i >= to; i--) add(1'b1, 1'b1, b, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'(i));
    endtask

    initial begin
        exp_t e;
        // Reset, then one full attack
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        attack_from_idle(0);
        idle(1'b0);
        // Hit on the second active frame, then a combo reload at frames_left=3
        attack_from_idle(16);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd14);
        stun_run(13, 3, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd14);
        stun_run(13, 0, 1'b0);
        idle(1'b0);
        // Hit and block together; block alone during hitstun changes nothing
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'd14);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'd13);
        stun_run(12, 0, 1'b0);
        idle(1'b0);
        // Buffered press at frames_left=2 chains straight into STARTUP
        attack_from_idle(2);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'd1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'd0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd4);
        attack_tail(10);
        // Early press at frames_left=10 is discarded
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'd9);
        for (int i = 8; i >= 0; i--) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'(i));
        idle(1'b0);
        // Block with a coincident press, reload, button held through the stun
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'd9);
        stun_run(8, 5, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'd9);
        stun_run(8, 0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd4);
        // Round stops during STARTUP
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        // Reset during RECOVERY with a press already buffered
        attack_from_idle(3);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'd2);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) idle(1'b0);

        reset_n = 1'b0; game_active = 1'b1; attack_btn = 1'b0;
        got_hit = 1'b0; got_blocked = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk_game);
            reset_n     = vecs[n].rst_n;
            game_active = vecs[n].ga;
            attack_btn  = vecs[n].btn;
            got_hit     = vecs[n].hit;
            got_blocked = vecs[n].blk;
            e.idx = n; e.ph = vecs[n].ph; e.st = vecs[n].st;
            e.stn = vecs[n].stn; e.mv = vecs[n].mv; e.fl = vecs[n].fl;
            exp_q.push_back(e);
            @(posedge clk_game);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at vec%0d", n);
            end else begin
                e = exp_q.pop_front();
                if ({attack_phase, attack_start, stunned, move_enable, frames_left} !==
                    {e.ph, e.st, e.stn, e.mv, e.fl}) begin
                    errors++;
                    $display("FAIL vec%0d: got ph=%b start=%b stun=%b move=%b fl=%0d, want ph=%b start=%b stun=%b move=%b fl=%0d",
                             e.idx, attack_phase, attack_start, stunned, move_enable, frames_left,
                             e.ph, e.st, e.stn, e.mv, e.fl);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/attack_sequencer.md
Name: attack_sequencer

Overview:
Per-player attack/stun controller that produces the attack_phase code consumed by the hit detection stage. It sequences the phases IDLE -> STARTUP -> ACTIVE -> RECOVERY with frame counters. It applies hitstun and blockstun when that stage reports a hit or block against this player, and gates movement. One instance is built per player. One clk_game cycle equals one game frame.

Parameters:
STARTUP_FRAMES, 5, frames spent in STARTUP (must be >=1)
ACTIVE_FRAMES, 2, frames spent in ACTIVE (must be >=1)
RECOVERY_FRAMES, 16, frames spent in RECOVERY (must be >=1)
HITSTUN_FRAMES, 15, frames locked after being hit (must be >=1)
BLOCKSTUN_FRAMES, 10, frames locked after blocking (must be >=1)
BUFFER_FRAMES, 4, final RECOVERY frames during which a new press is buffered (must be <=RECOVERY_FRAMES)
CNT_W, 5, frame counter width; 2^CNT_W must exceed every *_FRAMES value

Ports:
clk_game  in  1  game/frame clock
reset_n  in  1  synchronous active-low reset
game_active  in  1  1 = round running; 0 forces IDLE
attack_btn  in  1  raw level of the attack button, already synchronised
got_hit  in  1  1-cycle pulse: opponent's attack hit this player
got_blocked  in  1  1-cycle pulse: this player blocked opponent's attack
attack_phase  out  2  00 IDLE, 01 STARTUP, 10 ACTIVE, 11 RECOVERY
attack_start  out  1  1-cycle pulse on entry to STARTUP
stunned  out  1  1 while in HITSTUN or BLOCKSTUN
move_enable  out  1  1 only in IDLE state with game_active=1
frames_left  out  CNT_W  remaining frames in current timed state, minus 1; 0 in IDLE

Behaviour:
- Reset: all of the following are cleared on a clk_game edge with reset_n=0.
  - Cleared to 0: attack_phase=00, attack_start=0, stunned=0, move_enable=0, frames_left=0.
  - Internal: state=IDLE, btn_prev=0, buffer flag=0.
- All outputs are registered. There is no combinational input-to-output path.
- Internal states are IDLE, STARTUP, ACTIVE, RECOVERY, HITSTUN and BLOCKSTUN.
  - attack_phase shows the matching code for the four attack states.
  - attack_phase is 00 in HITSTUN and BLOCKSTUN.
- Press detection: press = attack_btn & ~btn_prev. btn_prev updates every non-reset cycle in every state, so a button held through stun does not re-trigger.
- Timed state entry: counter loads <STATE>_FRAMES-1. The counter decrements each cycle. The state exits on the cycle the counter is 0, so each state lasts exactly <STATE>_FRAMES cycles.
- Transitions, in priority order each cycle:
  1. game_active=0: go to IDLE, clear the buffer, set counter=0, suppress attack_start.
  2. got_hit=1: go to HITSTUN, load HITSTUN_FRAMES-1, clear the buffer.
     - This interrupts any state, including ACTIVE.
     - A got_hit during HITSTUN reloads the counter (combo extension).
  3. got_blocked=1:
     - From HITSTUN: ignored.
     - Otherwise: go to BLOCKSTUN, load BLOCKSTUN_FRAMES-1, clear the buffer.
     - A got_blocked during BLOCKSTUN reloads the counter.
  4. Normal sequencing:
     - IDLE + press: go to STARTUP; attack_start=1 in the first STARTUP cycle.
     - STARTUP, counter 0: go to ACTIVE.
     - ACTIVE, counter 0: go to RECOVERY.
     - RECOVERY, press while counter < BUFFER_FRAMES: set the buffer flag.
     - RECOVERY, press earlier than that: discarded.
     - RECOVERY, counter 0, buffer set: go straight to STARTUP, clear the buffer, pulse attack_start.
     - RECOVERY, counter 0, buffer clear: go to IDLE.
     - HITSTUN or BLOCKSTUN, counter 0: go to IDLE. Presses are ignored in stun.
- Latency: a press sampled at edge N gives attack_phase=01 after edge N. attack_phase=10 follows after edge N+STARTUP_FRAMES.
- ACTIVE is entered once per attack, so the hit detection stage sees exactly one rising transition per attack.
- Simultaneous got_hit and got_blocked: got_hit wins.
- A press coincident with got_hit or got_blocked is discarded.
- frames_left equals the live counter value. It must never underflow or wrap.
- reset_n low mid-attack: IDLE on that edge, with no attack_start pulse.

Test Plan:
- Reset then single press, defaults: attack_phase 01 for 5 cycles, 10 for 2, 11 for 16, then 00; attack_start high for exactly 1 cycle; move_enable 0 throughout, 1 after return to IDLE.
- got_hit pulse on the 2nd ACTIVE cycle: next cycle attack_phase=00, stunned=1, frames_left=14; stunned stays 1 for 15 cycles; second got_hit at frames_left=3 reloads to 14.
- got_hit and got_blocked asserted together from IDLE: HITSTUN entered with frames_left=14. got_blocked alone in HITSTUN: no change.
- Press at RECOVERY frames_left=2: after RECOVERY, attack_phase goes 11 -> 01 with no IDLE cycle and attack_start=1. Press at frames_left=10: discarded, IDLE follows.
- Button held high across a 10-frame BLOCKSTUN: no attack starts on stun exit; release then press starts STARTUP.
- game_active dropped during STARTUP, and separately reset_n=0 during RECOVERY: next cycle all outputs read 0/IDLE, buffer cleared, no attack_start.
